// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: register-file index width and data word.
package cpu_types_pkg;
   localparam int REG_W  = 5;
   localparam int WORD_W = 32;

   typedef logic [REG_W-1:0]  regbits_t;
   typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/data_path_muxs_pkg.sv
// Datapath mux selection types and the pipeline controller state enum.
package data_path_muxs_pkg;
   typedef enum logic [0:0] {
      PC_SRC_NPC    = 1'b0,
      PC_SRC_BRANCH = 1'b1
   } pc_src_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } pipe_ctrl_state_t;
endpackage

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
module hazard_unit
   import cpu_types_pkg::*;
(
   input  logic     dREN_ID_EX,
   input  logic     WEN_ID_EX,
   input  regbits_t Rt_ID_EX,
   input  regbits_t Rs_IF_ID,
   input  regbits_t Rt_IF_ID,
   output logic     lu_hazard
);

   logic dest_live;
   logic src_match;

   // $zero is never a real dependency, so a load targeting it never stalls.
   assign dest_live = dREN_ID_EX & WEN_ID_EX & (Rt_ID_EX != '0);
   assign src_match = (Rt_ID_EX == Rs_IF_ID) | (Rt_ID_EX == Rt_IF_ID);
   assign lu_hazard = dest_live & src_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per-stage enables/flushes, PC control, halt drain and
// saturating stall/flush performance counters.
module pipeline_ctrl
   import cpu_types_pkg::*;
   import data_path_muxs_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             dREN_EX_MEM,
   input  logic             dWEN_EX_MEM,
   input  logic             halt_EX_MEM,
   input  logic             branch_taken_EX_MEM,
   input  logic             dREN_ID_EX,
   input  logic             WEN_ID_EX,
   input  regbits_t         Rt_ID_EX,
   input  regbits_t         Rs_IF_ID,
   input  regbits_t         Rt_IF_ID,
   output logic             pc_enable,
   output logic             pc_sel_branch,
   output logic             enable_IF_ID,
   output logic             enable_ID_EX,
   output logic             enable_EX_MEM,
   output logic             enable_MEM_WB,
   output logic             flush_IF_ID,
   output logic             flush_ID_EX,
   output logic             flush_EX_MEM,
   output logic             halt,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output pipe_ctrl_state_t state_dbg
);

   pipe_ctrl_state_t state_q, state_d;
   logic             halt_q, halt_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;

   logic mem_busy;
   logic mem_stall;
   logic lu_hazard;
   logic stall_inc;
   logic flush_inc;

   assign mem_busy  = dREN_EX_MEM | dWEN_EX_MEM;
   assign mem_stall = mem_busy & ~dhit;

   hazard_unit u_hazard_unit (
      .dREN_ID_EX (dREN_ID_EX),
      .WEN_ID_EX  (WEN_ID_EX),
      .Rt_ID_EX   (Rt_ID_EX),
      .Rs_IF_ID   (Rs_IF_ID),
      .Rt_IF_ID   (Rt_IF_ID),
      .lu_hazard  (lu_hazard)
   );

   always_comb begin
      state_d       = state_q;
      pc_enable     = 1'b0;
      pc_sel_branch = 1'b0;
      enable_IF_ID  = 1'b0;
      enable_ID_EX  = 1'b0;
      enable_EX_MEM = 1'b0;
      enable_MEM_WB = 1'b0;
      flush_IF_ID   = 1'b0;
      flush_ID_EX   = 1'b0;
      flush_EX_MEM  = 1'b0;
      stall_inc     = 1'b0;
      flush_inc     = 1'b0;

      case (state_q)
         RUN: begin
            if (mem_stall) begin
               stall_inc = 1'b1;
            end else if (halt_EX_MEM) begin
               // Let the halt itself retire into WB, freeze everything behind it.
               enable_MEM_WB = 1'b1;
               stall_inc     = 1'b1;
               state_d       = DRAIN;
            end else if (branch_taken_EX_MEM) begin
               pc_enable     = 1'b1;
               pc_sel_branch = 1'b1;
               enable_IF_ID  = 1'b1;
               enable_ID_EX  = 1'b1;
               enable_EX_MEM = 1'b1;
               enable_MEM_WB = 1'b1;
               flush_IF_ID   = 1'b1;
               flush_ID_EX   = 1'b1;
               flush_EX_MEM  = 1'b1;
               flush_inc     = 1'b1;
            end else if (lu_hazard || !ihit) begin
               // Hold fetch/decode, inject a bubble into EX, drain the back end.
               enable_ID_EX  = 1'b1;
               enable_EX_MEM = 1'b1;
               enable_MEM_WB = 1'b1;
               flush_ID_EX   = 1'b1;
               stall_inc     = 1'b1;
            end else begin
               pc_enable     = 1'b1;
               enable_IF_ID  = 1'b1;
               enable_ID_EX  = 1'b1;
               enable_EX_MEM = 1'b1;
               enable_MEM_WB = 1'b1;
            end
         end
         DRAIN:   state_d = HALTED;
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      halt_d        = (state_d == HALTED);
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (stall_inc && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end
      if (flush_inc && (flush_count_q != '1)) begin
         flush_count_d = flush_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q       <= RUN;
         halt_q        <= 1'b0;
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         state_q       <= state_d;
         halt_q        <= halt_d;
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign halt        = halt_q;
   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;
   assign state_dbg   = state_q;

endmodule
